zap_mode16_halfword_sequencer: RTL

- Sits between the instruction fetch/cache return path and the 16-bit decode stage.
- Accepts one 32-bit fetch word per handshake and schedules it as up to two 16-bit halfwords in compressed mode (T=1), or as a single 32-bit beat in normal mode.
- Each halfword leaves with its own PC, abort flag and predictor status.
- Owns the fetch-side ready signal, so fetch is throttled while a buffered word still has halfwords pending.

---
 rtl/zap_mode16_halfword_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/zap_mode16_halfword_sequencer.sv
// Splits 32-bit fetch words into 16-bit compressed-mode halfword beats, or passes
// them through as single 32-bit beats; owns the fetch-side ready.
module zap_mode16_halfword_sequencer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_stall,
  input  logic        i_cpsr_ff_t,
  input  logic [31:0] i_instruction,
  input  logic        i_instruction_valid,
  input  logic [31:0] i_pc_ff,
  input  logic        i_iabort,
  input  logic [1:0]  i_taken,
  output logic        o_ready,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_half,
  output logic [31:0] o_pc,
  output logic        o_iabort,
  output logic [1:0]  o_taken
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LO    = 2'd1,
    S_HI    = 2'd2,
    S_W32   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [29:0] base_q, base_d;
  logic        abort_q, abort_d;
  logic [1:0]  taken_q, taken_d;
  logic        t_q, t_d;
  logic        consume;
  logic        accept;
  logic        last_beat;
  logic        unused_pc_bit;

  // Byte-offset bit of the PC is meaningless for 16/32-bit units.
  assign unused_pc_bit = i_pc_ff[0];

  assign last_beat = (state_q == S_HI) || (state_q == S_W32);
  assign o_valid   = (state_q != S_EMPTY);
  assign consume   = o_valid && !i_stall;
  assign o_ready   = !i_reset && !i_clear &&
                     ((state_q == S_EMPTY) || (last_beat && !i_stall));
  assign accept    = o_ready && i_instruction_valid;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    buf_d   = buf_q;
    base_d  = base_q;
    abort_d = abort_q;
    taken_d = taken_q;
    t_d     = t_q;
    if (i_clear) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      buf_d   = i_iabort ? 32'd0 : i_instruction;
      base_d  = i_pc_ff[31:2];
      abort_d = i_iabort;
      taken_d = i_taken;
      t_d     = i_cpsr_ff_t;
      // An aborted word is always a single beat; an odd-halfword PC skips the low half.
      if (!i_cpsr_ff_t)                 state_d = S_W32;
      else if (i_iabort || i_pc_ff[1])  state_d = S_HI;
      else                              state_d = S_LO;
    end else if (consume) begin
      state_d = (state_q == S_LO) ? S_HI : S_EMPTY;
    end
  end

  always_comb begin
    o_instruction = 32'd0;
    o_pc          = 32'd0;
    o_half        = 1'b0;
    o_iabort      = 1'b0;
    o_taken       = 2'b00;
    unique case (state_q)
      S_LO: begin
        o_instruction = {16'd0, buf_q[15:0]};
        o_pc          = {base_q, 2'b00};
        o_half        = t_q;
        o_iabort      = abort_q;
      end
      S_HI: begin
        o_instruction = {16'd0, buf_q[31:16]};
        o_pc          = {base_q, 2'b10};
        o_half        = t_q;
        o_iabort      = abort_q;
        o_taken       = taken_q;
      end
      S_W32: begin
        o_instruction = buf_q;
        o_pc          = {base_q, 2'b00};
        o_iabort      = abort_q;
        o_taken       = taken_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_reset) begin
      state_q <= S_EMPTY;
      buf_q   <= 32'd0;
      base_q  <= 30'd0;
      abort_q <= 1'b0;
      taken_q <= 2'b00;
      t_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      base_q  <= base_d;
      abort_q <= abort_d;
      taken_q <= taken_d;
      t_q     <= t_d;
    end
  end

endmodule
